jt12_slotreg: RTL and testbench

//  Parametrised time-slot register file for FM operator/channel settings.

---
 rtl/jt12_slotreg.sv | 189 ++++++++++++++++++
 tb/tb_jt12_slotreg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_slotreg.sv
// jt12_slotreg: time-slot register file for FM operator/channel words with a one-entry write
// buffer committed when its slot comes round. Readback port enabled by JT12_SLOTREG_RDBACK_EN.
module jt12_slotreg #(
   parameter int unsigned NUM_CH  = 6,
   parameter int unsigned NUM_OP  = 4,
   parameter int unsigned OPREG_W = 44,
   parameter int unsigned CHREG_W = 27,
   parameter logic [OPREG_W-1:0] OP_RSTVAL = '0,
   parameter logic [CHREG_W-1:0] CH_RSTVAL = '0,
   localparam int unsigned CHW = $clog2(NUM_CH),
   localparam int unsigned OPW = $clog2(NUM_OP)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_en,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic               wr_is_ch,
   input  logic [CHW-1:0]     wr_ch,
   input  logic [OPW-1:0]     wr_op,
   input  logic [OPREG_W-1:0] wr_mask,
   input  logic [OPREG_W-1:0] wr_data,
   output logic               wr_err,
   output logic [CHW-1:0]     cur_ch,
   output logic [OPW-1:0]     cur_op,
   output logic               zero,
   output logic [OPREG_W-1:0] op_q,
   output logic [CHREG_W-1:0] ch_q,
   input  logic               rd_req,
   input  logic               rd_is_ch,
   input  logic [CHW-1:0]     rd_ch,
   input  logic [OPW-1:0]     rd_op,
   output logic               rd_busy,
   output logic               rd_dv,
   output logic [OPREG_W-1:0] rd_data
);

   localparam int unsigned NSLOT = NUM_CH * NUM_OP;
   localparam int unsigned SW    = $clog2(NSLOT);
   localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);
   localparam logic [OPW-1:0] LAST_OP   = OPW'(NUM_OP - 1);
   localparam logic [SW-1:0]  LAST_SLOT = SW'(NSLOT - 1);

   logic [CHW-1:0] cnt_ch_q, cnt_ch_d;
   logic [OPW-1:0] cnt_op_q, cnt_op_d;
   logic [SW-1:0]  slot_q, slot_d;
   logic           zero_q;

   // Channel is the inner loop; slot_q tracks cnt_op*NUM_CH+cnt_ch directly
   always_comb begin
      cnt_ch_d = cnt_ch_q + 1'b1;
      cnt_op_d = cnt_op_q;
      slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
      if (cnt_ch_q == LAST_CH) begin
         cnt_ch_d = '0;
         cnt_op_d = (cnt_op_q == LAST_OP) ? '0 : cnt_op_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_ch_q <= '0;
         cnt_op_q <= '0;
         slot_q   <= '0;
         zero_q   <= 1'b1;
      end else if (clk_en) begin
         cnt_ch_q <= cnt_ch_d;
         cnt_op_q <= cnt_op_d;
         slot_q   <= slot_d;
         zero_q   <= (slot_d == '0);
      end
   end

   logic               pend_q, pend_is_ch_q, wr_err_q;
   logic [CHW-1:0]     pend_ch_q;
   logic [SW-1:0]      pend_slot_q;
   logic [OPREG_W-1:0] pend_mask_q, pend_data_q;
   logic               wr_acc, wr_bad, commit;
   logic [SW-1:0]      wr_slot;

   assign wr_acc  = wr_valid & ~pend_q;
   assign wr_bad  = (32'(wr_ch) >= NUM_CH) || (!wr_is_ch && (32'(wr_op) >= NUM_OP));
   assign wr_slot = SW'(32'(wr_op) * NUM_CH + 32'(wr_ch));
   assign commit  = clk_en & pend_q &
                    (pend_is_ch_q ? (pend_ch_q == cnt_ch_q) : (pend_slot_q == slot_q));

   // Bad addresses are dropped at the accept edge and only flag wr_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q       <= 1'b0;
         pend_is_ch_q <= 1'b0;
         pend_ch_q    <= '0;
         pend_slot_q  <= '0;
         pend_mask_q  <= '0;
         pend_data_q  <= '0;
         wr_err_q     <= 1'b0;
      end else begin
         wr_err_q <= wr_acc & wr_bad;
         if (commit) begin
            pend_q <= 1'b0;
         end else if (wr_acc && !wr_bad) begin
            pend_q       <= 1'b1;
            pend_is_ch_q <= wr_is_ch;
            pend_ch_q    <= wr_ch;
            pend_slot_q  <= wr_slot;
            pend_mask_q  <= wr_mask;
            pend_data_q  <= wr_data;
         end
      end
   end

   logic [OPREG_W-1:0] op_mem [NSLOT];
   logic [CHREG_W-1:0] ch_mem [NUM_CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSLOT; i++) op_mem[i] <= OP_RSTVAL;
         for (int i = 0; i < NUM_CH; i++) ch_mem[i] <= CH_RSTVAL;
      end else if (commit) begin
         if (pend_is_ch_q) begin
            ch_mem[pend_ch_q] <= (ch_mem[pend_ch_q] & ~pend_mask_q[CHREG_W-1:0]) |
                                 (pend_data_q[CHREG_W-1:0] & pend_mask_q[CHREG_W-1:0]);
         end else begin
            op_mem[pend_slot_q] <= (op_mem[pend_slot_q] & ~pend_mask_q) |
                                   (pend_data_q & pend_mask_q);
         end
      end
   end

   assign wr_ready = ~pend_q;
   assign wr_err   = wr_err_q;
   assign cur_ch   = cnt_ch_q;
   assign cur_op   = cnt_op_q;
   assign zero     = zero_q;
   assign op_q     = op_mem[slot_q];
   assign ch_q     = ch_mem[cnt_ch_q];

`ifdef JT12_SLOTREG_RDBACK_EN
   logic               rd_busy_q, rd_dv_q, rd_is_ch_q;
   logic [CHW-1:0]     rd_ch_q;
   logic [SW-1:0]      rd_slot_q;
   logic [OPREG_W-1:0] rd_data_q;
   logic               rd_bad, rd_hit;

   assign rd_bad = (32'(rd_ch) >= NUM_CH) || (!rd_is_ch && (32'(rd_op) >= NUM_OP));
   assign rd_hit = clk_en & rd_busy_q &
                   (rd_is_ch_q ? (rd_ch_q == cnt_ch_q) : (rd_slot_q == slot_q));

   // Storage reads here see the word before any commit on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_busy_q  <= 1'b0;
         rd_dv_q    <= 1'b0;
         rd_is_ch_q <= 1'b0;
         rd_ch_q    <= '0;
         rd_slot_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_dv_q <= 1'b0;
         if (rd_hit) begin
            rd_data_q <= rd_is_ch_q ? OPREG_W'(ch_mem[rd_ch_q]) : op_mem[rd_slot_q];
            rd_dv_q   <= 1'b1;
            rd_busy_q <= 1'b0;
         end else if (rd_req && !rd_busy_q) begin
            if (rd_bad) begin
               rd_data_q <= '0;
               rd_dv_q   <= 1'b1;
            end else begin
               rd_busy_q  <= 1'b1;
               rd_is_ch_q <= rd_is_ch;
               rd_ch_q    <= rd_ch;
               rd_slot_q  <= SW'(32'(rd_op) * NUM_CH + 32'(rd_ch));
            end
         end
      end
   end

   assign rd_busy = rd_busy_q;
   assign rd_dv   = rd_dv_q;
   assign rd_data = rd_data_q;
`else
   logic unused_rd;
   assign unused_rd = ^{rd_req, rd_is_ch, rd_ch, rd_op};
   assign rd_busy   = 1'b0;
   assign rd_dv     = 1'b0;
   assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_jt12_slotreg.sv
// Randomised self-checking bench for jt12_slotreg against a slot-arithmetic reference model.
module tb_jt12_slotreg;

   localparam int NCH = 6;
   localparam int NOP = 4;
   localparam int NSL = NCH * NOP;
   localparam int BOUND = 400;

   logic clk = 1'b0, rst = 1'b0, clk_en = 1'b0;
   logic wr_valid = 1'b0, wr_is_ch = 1'b0;
   logic [2:0] wr_ch = '0;
   logic [1:0] wr_op = '0;
   logic [43:0] wr_mask = '0, wr_data = '0;
   logic wr_ready, wr_err, zero;
   logic [2:0] cur_ch;
   logic [1:0] cur_op;
   logic [43:0] op_q;
   logic [26:0] ch_q;
   logic rd_req = 1'b0, rd_is_ch = 1'b0;
   logic [2:0] rd_ch = '0;
   logic [1:0] rd_op = '0;
   logic rd_busy, rd_dv;
   logic [43:0] rd_data;

   int n_checks = 0;
   int n_errors = 0;
   bit en_rand = 0;

   jt12_slotreg dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_is_ch(wr_is_ch), .wr_ch(wr_ch),
      .wr_op(wr_op), .wr_mask(wr_mask), .wr_data(wr_data), .wr_err(wr_err),
      .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero), .op_q(op_q), .ch_q(ch_q),
      .rd_req(rd_req), .rd_is_ch(rd_is_ch), .rd_ch(rd_ch), .rd_op(rd_op),
      .rd_busy(rd_busy), .rd_dv(rd_dv), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // Reference model: storage arrays plus a linear slot number
   int          m_slot;
   logic [43:0] m_op [NSL];
   logic [26:0] m_ch [NCH];
   bit          m_pend, m_pis_ch, m_err;
   int          m_pch, m_pop;
   logic [43:0] m_pmask, m_pdata;
   bit          m_rbusy, m_ris_ch, m_rdv;
   int          m_rch, m_rop;
   logic [43:0] m_rdata;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_slot = 0;
      for (int i = 0; i < NSL; i++) m_op[i] = '0;
      for (int i = 0; i < NCH; i++) m_ch[i] = '0;
      m_pend = 0; m_err = 0; m_rbusy = 0; m_rdv = 0; m_rdata = '0;
   endtask

   task automatic model_step();
      int ch = m_slot % NCH;
      int op = m_slot / NCH;
      bit was_pend = m_pend;
      bit was_busy = m_rbusy;
      m_rdv = 0;
`ifdef JT12_SLOTREG_RDBACK_EN
      if (clk_en && was_busy && m_rch == ch && (m_ris_ch || m_rop == op)) begin
         m_rdata = m_ris_ch ? {17'b0, m_ch[ch]} : m_op[m_slot];
         m_rdv = 1; m_rbusy = 0;
      end else if (rd_req && !was_busy) begin
         if (int'(rd_ch) >= NCH) begin
            m_rdv = 1; m_rdata = '0;
         end else begin
            m_rbusy = 1; m_ris_ch = rd_is_ch; m_rch = int'(rd_ch); m_rop = int'(rd_op);
         end
      end
`else
      if (was_busy) m_rbusy = 0;
`endif
      if (clk_en && was_pend && m_pch == ch && (m_pis_ch || m_pop == op)) begin
         if (m_pis_ch) m_ch[ch] = (m_ch[ch] & ~m_pmask[26:0]) | (m_pdata[26:0] & m_pmask[26:0]);
         else m_op[m_slot] = (m_op[m_slot] & ~m_pmask) | (m_pdata & m_pmask);
         m_pend = 0;
      end
      m_err = 0;
      if (wr_valid && !was_pend) begin
         if (int'(wr_ch) >= NCH) m_err = 1;
         else begin
            m_pend = 1; m_pis_ch = wr_is_ch; m_pch = int'(wr_ch); m_pop = int'(wr_op);
            m_pmask = wr_mask; m_pdata = wr_data;
         end
      end
      if (clk_en) m_slot = (m_slot + 1) % NSL;
   endtask

   task automatic check_all(input string ctx);
      check_eq({ctx, ".cur_ch"}, 64'(cur_ch), 64'(m_slot % NCH));
      check_eq({ctx, ".cur_op"}, 64'(cur_op), 64'(m_slot / NCH));
      check_eq({ctx, ".zero"}, 64'(zero), 64'(m_slot == 0));
      check_eq({ctx, ".wr_ready"}, 64'(wr_ready), 64'(!m_pend));
      check_eq({ctx, ".wr_err"}, 64'(wr_err), 64'(m_err));
      check_eq({ctx, ".op_q"}, 64'(op_q), 64'(m_op[m_slot]));
      check_eq({ctx, ".ch_q"}, 64'(ch_q), 64'(m_ch[m_slot % NCH]));
      check_eq({ctx, ".rd_busy"}, 64'(rd_busy), 64'(m_rbusy));
      check_eq({ctx, ".rd_dv"}, 64'(rd_dv), 64'(m_rdv));
      check_eq({ctx, ".rd_data"}, 64'(rd_data), 64'(m_rdata));
   endtask

   task automatic tick();
      if (en_rand) clk_en = ($urandom_range(0, 2) == 0);
      model_step();
      @(posedge clk);
      #1;
      check_all("run");
   endtask

   task automatic do_reset();
      wr_valid = 0; rd_req = 0;
      rst = 1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      rst = 0;
   endtask

   task automatic send_write(input bit is_ch, input int ch, input int op,
                             input logic [43:0] mask, input logic [43:0] data);
      bit done = 0;
      wr_is_ch = is_ch; wr_ch = 3'(ch); wr_op = 2'(op);
      wr_mask = mask; wr_data = data; wr_valid = 1;
      for (int i = 0; i < BOUND && !done; i++) begin
         bit rdy = wr_ready;
         tick();
         done = rdy;
      end
      wr_valid = 0;
      check_eq("wr_accept_timeout", 64'(done), 64'(1));
   endtask

   task automatic wait_ready();
      for (int i = 0; i < BOUND && !wr_ready; i++) tick();
      check_eq("commit_timeout", 64'(wr_ready), 64'(1));
   endtask

   task automatic wait_slot(input int ch, input int op);
      for (int i = 0; i < BOUND && !(int'(cur_ch) == ch && int'(cur_op) == op); i++) tick();
      check_eq("slot_timeout", 64'(int'(cur_ch) == ch && int'(cur_op) == op), 64'(1));
   endtask

   initial begin
      int low;
      logic [63:0] r;
      #2;
      do_reset();
      clk_en = 1;
      for (int i = 0; i < 2 * NSL + 3; i++) tick();

      // Operator write at ch2/op3 lands in the low 7 bits of slot 20 only
      send_write(0, 2, 3, 44'h7F, 44'h45);
      wait_ready();
      wait_slot(2, 3);
      check_eq("op_wr_c2o3", 64'(op_q), 64'h45);

      // Channel write accepted at slot 0 commits at slot 5
      wait_slot(0, 0);
      send_write(1, 5, 0, 44'h7, 44'h3);
      low = 0;
      while (!wr_ready && low < 50) begin
         tick();
         low++;
      end
      check_eq("ch_wr_ready_low", 64'(low), 64'd5);
      wait_slot(5, 1);
      check_eq("ch_wr_c5", 64'(ch_q), 64'h3);

      // Back-to-back writes to one slot must commit in order
      do_reset();
      send_write(0, 0, 0, 44'hFF, 44'h11);
      send_write(0, 0, 0, 44'h0F, 44'h02);
      wait_ready();
      wait_slot(0, 0);
      check_eq("b2b_order", 64'(op_q), 64'h12);

      // Out-of-range channel: error pulse only
      send_write(0, 7, 1, 44'hFFF, 44'hABC);
      check_eq("wr_err_pulse", 64'(wr_err), 64'(1));
      tick();
      check_eq("wr_err_clear", 64'(wr_err), 64'(0));

      // Reset while a write is pending drops it
      wait_slot(0, 0);
      send_write(0, 3, 3, '1, '1);
      tick();
      do_reset();
      check_eq("rst_pend_ready", 64'(wr_ready), 64'(1));
      wait_slot(3, 3);
      check_eq("rst_pend_nocommit", 64'(op_q), 64'h0);

`ifdef JT12_SLOTREG_RDBACK_EN
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         clk_en = 1;
         en_rand = (pass == 1);
         send_write(0, 1, 2, 44'hFFFF, 44'hBEEF);
         wait_ready();
         rd_is_ch = 0; rd_ch = 3'd1; rd_op = 2'd2; rd_req = 1;
         tick();
         rd_req = 0;
         for (int i = 0; i < BOUND && !rd_dv; i++) tick();
         check_eq("rd_dv_seen", 64'(rd_dv), 64'(1));
         check_eq("rd_new_word", 64'(rd_data), 64'hBEEF);
         rd_ch = 3'd7; rd_req = !rd_busy;
         tick();
         rd_req = 0;
         check_eq("rd_bad_dv", 64'(rd_dv), 64'(1));
         check_eq("rd_bad_data", 64'(rd_data), 64'h0);
      end
      en_rand = 0;
`endif

      // Random traffic, clk_en constant then toggling roughly 1 in 3
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         clk_en = 1;
         en_rand = (pass == 1);
         for (int i = 0; i < 800; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_is_ch = $urandom_range(0, 1) == 1;
            wr_ch = 3'($urandom_range(0, 7));
            wr_op = 2'($urandom_range(0, 3));
            r = {$urandom(), $urandom()};
            wr_mask = r[43:0];
            r = {$urandom(), $urandom()};
            wr_data = r[43:0];
            rd_req = ($urandom_range(0, 3) == 0);
            rd_is_ch = $urandom_range(0, 1) == 1;
            rd_ch = 3'($urandom_range(0, 7));
            rd_op = 2'($urandom_range(0, 3));
            tick();
         end
      end
      en_rand = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
